// File: rtl/traffic_sink.sv
// Ejection-port sink: consumes flits, returns credits, tracks per-VC packet framing and errors.
// Optional packet-length statistics are enabled with TRAFFIC_SINK_STATS_EN.
module traffic_sink #(
  parameter int FLIT_W = 16,
  parameter int DEST_W = 14,
  parameter int NUM_VC = 2,
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op,
  input  logic [31:0]       data,
  input  logic              flit_valid,
  input  logic [VC_W-1:0]   flit_vc,
  input  logic [FLIT_W-1:0] flit_in,
  output logic [NUM_VC-1:0] credit_out,
  output logic [9:0]        pkt_count,
  output logic [15:0]       flit_count,
  output logic [2:0]        err,
  output logic              done,
  output logic [9:0]        max_pkt_len
);

  localparam logic [2:0] OP_INIT = 3'd5;

  logic              armed_r;
  logic [9:0]        expected_r;
  logic [DEST_W-1:0] own_addr_r;
  logic [NUM_VC-1:0] vc_open_r;
  logic [9:0]        len_r [NUM_VC];

  logic              armed_s;
  logic [9:0]        expected_s;
  logic [DEST_W-1:0] own_addr_s;
  logic [NUM_VC-1:0] vc_open_s;
  logic [9:0]        len_s [NUM_VC];
  logic [NUM_VC-1:0] credit_s;
  logic [9:0]        pkt_s;
  logic [15:0]       flit_s;
  logic [2:0]        err_s;
  logic              done_s;
  logic              cmp_s;
  logic [9:0]        cmp_len_s;

  logic              init_s;
  logic              accept_s;
  logic              head_s;
  logic              tail_s;
  logic              dest_bad_s;
  logic [9:0]        len_inc_s;
  logic              unused_data_s;

  assign init_s        = (op == OP_INIT);
  assign accept_s      = flit_valid && !init_s && (32'(flit_vc) < NUM_VC);
  assign head_s        = flit_in[FLIT_W-1];
  assign tail_s        = flit_in[FLIT_W-2];
  assign dest_bad_s    = (flit_in[DEST_W-1:0] != own_addr_r);
  assign len_inc_s     = (len_r[flit_vc] == 10'd1023) ? 10'd1023 : len_r[flit_vc] + 10'd1;
  assign unused_data_s = ^data[21:DEST_W];

  // Next-state for framing, counters, errors and credit
  always_comb begin
    armed_s    = armed_r;
    expected_s = expected_r;
    own_addr_s = own_addr_r;
    vc_open_s  = vc_open_r;
    len_s      = len_r;
    credit_s   = {NUM_VC{1'b0}};
    pkt_s      = pkt_count;
    flit_s     = flit_count;
    err_s      = err;
    cmp_s      = 1'b0;
    cmp_len_s  = 10'd0;
    if (init_s) begin
      armed_s    = 1'b1;
      expected_s = data[31:22];
      own_addr_s = data[DEST_W-1:0];
      vc_open_s  = {NUM_VC{1'b0}};
      for (int i = 0; i < NUM_VC; i++) begin
        len_s[i] = 10'd0;
      end
      pkt_s      = 10'd0;
      flit_s     = 16'd0;
      err_s      = 3'd0;
    end else if (accept_s) begin
      credit_s[flit_vc] = 1'b1;
      if (armed_r) begin
        flit_s = flit_count + 16'd1;
        if (head_s) begin
          // A head inside an open packet abandons it and starts afresh
          if (vc_open_r[flit_vc]) begin
            err_s[0] = 1'b1;
          end else begin
            err_s[0] = err[0];
          end
          if (dest_bad_s) begin
            err_s[2] = 1'b1;
          end else begin
            err_s[2] = err[2];
          end
          len_s[flit_vc] = 10'd1;
          if (tail_s) begin
            vc_open_s[flit_vc] = 1'b0;
            cmp_s              = 1'b1;
            cmp_len_s          = 10'd1;
          end else begin
            vc_open_s[flit_vc] = 1'b1;
          end
        end else if (vc_open_r[flit_vc]) begin
          len_s[flit_vc] = len_inc_s;
          if (tail_s) begin
            vc_open_s[flit_vc] = 1'b0;
            cmp_s              = 1'b1;
            cmp_len_s          = len_inc_s;
          end else begin
            vc_open_s[flit_vc] = 1'b1;
          end
        end else begin
          err_s[1] = 1'b1;
        end
      end else begin
        flit_s = flit_count;
      end
    end else begin
      credit_s = {NUM_VC{1'b0}};
    end
    if (cmp_s && (pkt_count != 10'd1023)) begin
      pkt_s = pkt_count + 10'd1;
    end else begin
      pkt_s = pkt_s;
    end
    done_s = armed_s && (pkt_s >= expected_s) && (vc_open_s == {NUM_VC{1'b0}});
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_r    <= 1'b0;
      expected_r <= 10'd0;
      own_addr_r <= {DEST_W{1'b0}};
      vc_open_r  <= {NUM_VC{1'b0}};
      for (int i = 0; i < NUM_VC; i++) begin
        len_r[i] <= 10'd0;
      end
      credit_out <= {NUM_VC{1'b0}};
      pkt_count  <= 10'd0;
      flit_count <= 16'd0;
      err        <= 3'd0;
      done       <= 1'b0;
    end else begin
      armed_r    <= armed_s;
      expected_r <= expected_s;
      own_addr_r <= own_addr_s;
      vc_open_r  <= vc_open_s;
      len_r      <= len_s;
      credit_out <= credit_s;
      pkt_count  <= pkt_s;
      flit_count <= flit_s;
      err        <= err_s;
      done       <= done_s;
    end
  end

`ifdef TRAFFIC_SINK_STATS_EN
  // Longest completed packet since Init
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_pkt_len <= 10'd0;
    end else if (init_s) begin
      max_pkt_len <= 10'd0;
    end else if (cmp_s && (cmp_len_s > max_pkt_len)) begin
      max_pkt_len <= cmp_len_s;
    end else begin
      max_pkt_len <= max_pkt_len;
    end
  end
`else
  logic unused_stats_s;
  assign unused_stats_s = ^cmp_len_s;
  assign max_pkt_len    = 10'd0;
`endif

endmodule

// File: tb/tb_traffic_sink.sv
// Randomized and directed bench for traffic_sink against a packet-level reference model.
module tb_traffic_sink;
  localparam int FLIT_W = 16;
  localparam int DEST_W = 14;
  localparam int NUM_VC = 2;
  localparam int VC_W   = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        op = 3'd0;
  logic [31:0]       data = 32'd0;
  logic              flit_valid = 1'b0;
  logic [VC_W-1:0]   flit_vc = '0;
  logic [FLIT_W-1:0] flit_in = '0;
  logic [NUM_VC-1:0] credit_out;
  logic [9:0]        pkt_count;
  logic [15:0]       flit_count;
  logic [2:0]        err;
  logic              done;
  logic [9:0]        max_pkt_len;

  traffic_sink #(.FLIT_W(FLIT_W), .DEST_W(DEST_W), .NUM_VC(NUM_VC)) dut (
    .clk(clk), .rst(rst), .op(op), .data(data), .flit_valid(flit_valid),
    .flit_vc(flit_vc), .flit_in(flit_in), .credit_out(credit_out),
    .pkt_count(pkt_count), .flit_count(flit_count), .err(err), .done(done),
    .max_pkt_len(max_pkt_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: packet-level view of the sink
  int m_armed, m_expected, m_own, m_pkts, m_flits, m_err, m_maxlen, m_credit;
  int m_open [NUM_VC];
  int m_len  [NUM_VC];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input int h, input int t, input int dst);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_W-1] = h[0];
    f[FLIT_W-2] = t[0];
    f[DEST_W-1:0] = dst[DEST_W-1:0];
    return f;
  endfunction

  task automatic model_clear();
    m_armed = 0; m_expected = 0; m_own = 0; m_pkts = 0; m_flits = 0;
    m_err = 0; m_maxlen = 0; m_credit = 0;
    for (int i = 0; i < NUM_VC; i++) begin m_open[i] = 0; m_len[i] = 0; end
  endtask

  task automatic model_complete(input int len);
    m_pkts = (m_pkts < 1023) ? m_pkts + 1 : 1023;
    if (len > m_maxlen) m_maxlen = len;
  endtask

  task automatic model_step(input int o, input int d, input int v, input int vc, input int f);
    int h, t, dst;
    h = (f >> (FLIT_W-1)) & 1;
    t = (f >> (FLIT_W-2)) & 1;
    dst = f & ((1 << DEST_W) - 1);
    m_credit = 0;
    if (o == 5) begin
      m_armed = 1; m_expected = (d >> 22) & 1023; m_own = d & ((1 << DEST_W) - 1);
      m_pkts = 0; m_flits = 0; m_err = 0; m_maxlen = 0;
      for (int i = 0; i < NUM_VC; i++) begin m_open[i] = 0; m_len[i] = 0; end
    end else if (v != 0 && vc < NUM_VC) begin
      m_credit = 1 << vc;
      if (m_armed != 0) begin
        m_flits = (m_flits + 1) % 65536;
        if (h != 0) begin
          if (m_open[vc] != 0) m_err |= 1;
          if (dst != m_own) m_err |= 4;
          m_len[vc] = 1;
          m_open[vc] = (t == 0);
          if (t != 0) model_complete(1);
        end else if (m_open[vc] != 0) begin
          m_len[vc] = (m_len[vc] < 1023) ? m_len[vc] + 1 : 1023;
          if (t != 0) begin m_open[vc] = 0; model_complete(m_len[vc]); end
        end else begin
          m_err |= 2;
        end
      end
    end
  endtask

  function automatic int model_done();
    int any_open;
    any_open = 0;
    for (int i = 0; i < NUM_VC; i++) any_open |= m_open[i];
    return (m_armed != 0 && m_pkts >= m_expected && any_open == 0) ? 1 : 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".credit"}, 32'(credit_out), 32'(m_credit));
    check({tag, ".pkt"}, 32'(pkt_count), 32'(m_pkts));
    check({tag, ".flits"}, 32'(flit_count), 32'(m_flits));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".done"}, 32'(done), 32'(model_done()));
`ifdef TRAFFIC_SINK_STATS_EN
    check({tag, ".maxlen"}, 32'(max_pkt_len), 32'(m_maxlen));
`else
    check({tag, ".maxlen"}, 32'(max_pkt_len), 32'd0);
`endif
  endtask

  task automatic step(input string tag, input int o, input int d, input int v, input int vc, input int f);
    op = o[2:0]; data = d[31:0]; flit_valid = v[0]; flit_vc = vc[VC_W-1:0]; flit_in = f[FLIT_W-1:0];
    @(posedge clk); #1;
    model_step(o, d, v, vc, f);
    op = 3'd0; flit_valid = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_clear();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int init_word(input int exp_pkts, input int addr);
    return (exp_pkts << 22) | addr;
  endfunction

  initial begin
    model_clear();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Unarmed: credit only
    step("unarmed", 0, 0, 1, 0, mk(1, 0, 5));

    // Basic packets on two VCs
    step("init1", 5, init_word(2, 5), 0, 0, 0);
    step("v0h", 0, 0, 1, 0, mk(1, 0, 5));
    step("v0b", 0, 0, 1, 0, mk(0, 0, 0));
    step("v0t", 0, 0, 1, 0, mk(0, 1, 0));
    step("v1ht", 0, 0, 1, 1, mk(1, 1, 5));
    step("idle1", 0, 0, 0, 0, 0);

    // Interleaved 3-flit packets
    step("init2", 5, init_word(2, 5), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("il0", 0, 0, 1, 0, mk(i == 0, i == 2, 5));
      step("il1", 0, 0, 1, 1, mk(i == 0, i == 2, 5));
    end

    // Head inside open packet, then body on idle VC
    step("init3", 5, init_word(1, 5), 0, 0, 0);
    step("e0h", 0, 0, 1, 0, mk(1, 0, 5));
    step("e0h2", 0, 0, 1, 0, mk(1, 0, 5));
    step("e0t", 0, 0, 1, 0, mk(0, 1, 0));
    step("e1b", 0, 0, 1, 1, mk(0, 0, 0));

    // Wrong destination still counted
    step("init4", 5, init_word(1, 5), 0, 0, 0);
    step("dh", 0, 0, 1, 0, mk(1, 0, 7));
    step("dt", 0, 0, 1, 0, mk(0, 1, 0));

    // Init with a flit in the same cycle; expected 0
    step("init5", 5, init_word(0, 5), 1, 0, mk(1, 0, 5));
    step("rh", 0, 0, 1, 1, mk(1, 0, 5));
    step("rb", 0, 0, 1, 1, mk(0, 0, 0));
    do_reset("rst_mid");

    // Packets of 3, 7, 2 flits
    step("init6", 5, init_word(3, 5), 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      int n;
      n = (p == 0) ? 3 : (p == 1) ? 7 : 2;
      for (int k = 0; k < n; k++) step("len", 0, 0, 1, 0, mk(k == 0, k == n - 1, 5));
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int r, o, v, vc, f, addr;
      r = $urandom_range(0, 199);
      if (r < 3) begin
        addr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : 5;
        step("rinit", 5, init_word($urandom_range(0, 6), addr) | ($urandom_range(0, 255) << 14),
             $urandom_range(0, 1), $urandom_range(0, 1), mk(1, 0, 5));
      end else if (r == 3) begin
        do_reset("rrst");
      end else begin
        o = $urandom_range(0, 7);
        if (o == 5) o = 0;
        v = ($urandom_range(0, 9) < 7) ? 1 : 0;
        vc = $urandom_range(0, NUM_VC - 1);
        f = mk($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 5);
        step("rnd", o, 0, v, vc, f);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/traffic_sink.md
TRAFFIC_SINK -- requirements
Module: traffic_sink

Interface
REQ-001 SHALL have parameter FLIT_W, default 16, flit width; bit FLIT_W-1 = head, bit FLIT_W-2 = tail, bits DEST_W-1:0 = destination (head flits only).
REQ-002 SHALL have parameter DEST_W, default 14, destination address width.
REQ-003 SHALL have parameter NUM_VC, default 2, number of virtual channels; VC_W = max(1, clog2(NUM_VC)).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port op  in  3  command; 5 = Init, all other values = no command.
REQ-007 SHALL have port data  in  32  Init payload; [31:22] = expected packet total, [DEST_W-1:0] = own address.
REQ-008 SHALL have port flit_valid  in  1  flit present on flit_in this cycle.
REQ-009 SHALL have port flit_vc  in  VC_W  VC of flit_in.
REQ-010 SHALL have port flit_in  in  FLIT_W  ejected flit.
REQ-011 SHALL have port credit_out  out  NUM_VC  one-cycle credit pulse per consumed flit, one bit per VC.
REQ-012 SHALL have port pkt_count  out  10  completed packets since Init.
REQ-013 SHALL have port flit_count  out  16  consumed flits since Init.
REQ-014 SHALL have port err  out  3  sticky errors: [0] head inside open packet, [1] body/tail with no open packet, [2] head destination != own address.
REQ-015 SHALL have port done  out  1  all expected packets received, no packet open.
REQ-016 SHALL have port max_pkt_len  out  10  longest completed packet in flits.

Function
REQ-017 SHALL hold per-VC state IDLE or OPEN plus a 10-bit per-VC flit length counter.
REQ-018 SHALL set an armed flag on Init; while unarmed, flits are consumed with credit returned but no counter, state or error update.
REQ-019 SHALL, on Init, latch expected total and own address, clear pkt_count, flit_count, err, all VC states to IDLE, length counters to 0, and set armed.
REQ-020 SHALL ignore a flit_valid in the same cycle as Init (no credit, no count).
REQ-021 SHALL, on an accepted flit, increment flit_count (16-bit wrap) and pulse credit_out[flit_vc] exactly one cycle later.
REQ-022 SHALL treat head in IDLE as IDLE->OPEN, length = 1, and set err[2] if flit_in[DEST_W-1:0] != own address.
REQ-023 SHALL treat head in OPEN as error: set err[0], discard the open packet, restart with length = 1, with the same err[2] check.
REQ-024 SHALL treat a non-head flit in OPEN as length+1 (saturate 1023); if tail, OPEN->IDLE and packet completes.
REQ-025 SHALL treat a non-head flit in IDLE as error: set err[1], no state change.
REQ-026 SHALL treat head+tail in IDLE as a single-flit packet: completes immediately with length 1, state stays IDLE.
REQ-027 SHALL increment pkt_count (saturate 1023) on each completed packet.
REQ-028 SHALL make all outputs registered; pkt_count, flit_count, err visible the cycle after the accepting edge.
REQ-029 SHALL drive done = armed AND pkt_count >= expected AND all VCs IDLE; expected 0 gives done = 1 the cycle after Init.
REQ-030 SHALL ignore flit_vc >= NUM_VC: no credit, no count, no state change.

Reset
REQ-031 SHALL, on rst, asynchronously clear armed, expected, own address, counters, err, done, credit_out, max_pkt_len, and all VC states to IDLE.
REQ-032 SHALL drop any open packet on reset mid-packet, with no credit for flits in flight.

Configuration
REQ-033 SHALL, with TRAFFIC_SINK_STATS_EN defined, update max_pkt_len to max(current, completed length) on each completion and clear it on Init.
REQ-034 SHALL, without TRAFFIC_SINK_STATS_EN, tie max_pkt_len to 0 and omit its register; all else unchanged.

Verification
REQ-035 SHALL cover: Init expected=2, addr=0x005; VC0 head(dst 5), body, tail; VC1 head+tail dst 5 -> pkt_count=2, flit_count=4, done=1, err=0, credit_out pulses 1 cycle after each flit.
REQ-036 SHALL cover: interleaved VC0/VC1 3-flit packets alternating per cycle -> both complete, pkt_count=2, no errors.
REQ-037 SHALL cover: VC0 head, head, tail -> err[0]=1, pkt_count=1; then body on idle VC1 -> err[1]=1.
REQ-038 SHALL cover: head dst 0x007 with own 0x005 -> err[2]=1, packet still counted on tail.
REQ-039 SHALL cover: Init with flit_valid same cycle -> no credit, flit_count=0; rst mid-packet -> all outputs 0, done=0.
REQ-040 SHALL cover: STATS_EN packets of 3, 7, 2 flits -> max_pkt_len=7; without macro -> 0.
